ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/tb4004_pkg.sv | 38 +++
 rtl/ram_port_arbiter_if.sv | 34 +++
 rtl/ram_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004-style RAM port arbiter.
// Holds the microcycle encoding, the arbiter state enum and small helpers.
package tb4004_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycle_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    // The host may only start during the address phases, when the CPU never touches RAM.
    function automatic logic is_addr_phase(input logic [2:0] cyc);
        return (cyc == CYC_A1) || (cyc == CYC_A2) || (cyc == CYC_A3);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == CNT_MAX) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Host (debug/loader) side of the RAM port arbiter.
// The host drives the request fields; the arbiter returns grant, done and read data.
interface ram_port_arbiter_if;
    import tb4004_pkg::*;

    logic              hostReq;
    logic              hostWe;
    logic [ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0] hostDin;
    logic              hostGnt;
    logic              hostDone;
    logic [DATA_W-1:0] hostRdata;

    modport master (
        output hostReq,
        output hostWe,
        output hostAddr,
        output hostDin,
        input  hostGnt,
        input  hostDone,
        input  hostRdata
    );

    modport slave (
        input  hostReq,
        input  hostWe,
        input  hostAddr,
        input  hostDin,
        output hostGnt,
        output hostDone,
        output hostRdata
    );

endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU (always wins, zero latency) and a host
// debug/loader port. Host writes are enabled by defining RAM_ARB_HOST_WRITE_EN.
module ram_port_arbiter
    import tb4004_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic [2:0]        cycle,
    input  logic              cpuRe,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuDin,
    output logic [DATA_W-1:0] cpuDout,
    ram_port_arbiter_if.slave host,
    output logic              ramRe,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramDin,
    input  logic [DATA_W-1:0] ramDout,
    output logic [CNT_W-1:0]  conflictCnt
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              we_q;
    logic              we_d;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] din_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              gnt_q;
    logic              done_q;
    logic              cpu_act_s;
    logic              host_we_s;

    assign cpu_act_s = cpuRe | cpuWe;

`ifdef RAM_ARB_HOST_WRITE_EN
    assign host_we_s = host.hostWe;
`else
    assign host_we_s = 1'b0;
`endif

    // Next-state, latched request fields, capture data and abort counting.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (host.hostReq && is_addr_phase(cycle) && !cpu_act_s) begin
                    state_d = ST_ACCESS;
                    addr_d  = host.hostAddr;
                    we_d    = host_we_s;
                    din_d   = host.hostDin;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A CPU strobe here means the host cycle never reached the RAM.
                if (cpu_act_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = sat_inc(cnt_q);
                end else if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cpu_act_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = sat_inc(cnt_q);
                end else begin
                    state_d = ST_DONE;
                    rdata_d = ramDout;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, latched host fields and registered host-side outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            addr_q  <= 12'h000;
            we_q    <= 1'b0;
            din_q   <= 4'h0;
            rdata_q <= 4'h0;
            cnt_q   <= 8'h00;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            gnt_q   <= (state_d == ST_ACCESS) || (state_d == ST_CAPTURE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // RAM port mux: CPU passes straight through, host only drives during ACCESS.
    always_comb begin
        ramRe   = 1'b0;
        ramWe   = 1'b0;
        ramAddr = 12'h000;
        ramDin  = 4'h0;
        if (cpu_act_s) begin
            ramRe   = cpuRe;
            ramWe   = cpuWe;
            ramAddr = cpuAddr;
            ramDin  = cpuDin;
        end else if (state_q == ST_ACCESS) begin
            ramRe   = !we_q;
`ifdef RAM_ARB_HOST_WRITE_EN
            ramWe   = we_q;
`else
            ramWe   = 1'b0;
`endif
            ramAddr = addr_q;
            ramDin  = din_q;
        end else begin
            ramRe   = 1'b0;
            ramWe   = 1'b0;
            ramAddr = 12'h000;
            ramDin  = 4'h0;
        end
    end

    assign cpuDout        = ramDout;
    assign host.hostGnt   = gnt_q;
    assign host.hostDone  = done_q;
    assign host.hostRdata = rdata_q;
    assign conflictCnt    = cnt_q;

endmodule
